// File: rtl/change_dispenser.sv
// Pays a change amount out as quarters, dimes, then nickels with one timed eject pulse per coin.
// Optional per-tube coin inventory (refill input, empty flags) is enabled by defining CHANGE_INVENTORY_EN.
module change_dispenser #(
    parameter int PULSE_CYCLES = 5_000_000,
    parameter int GAP_CYCLES   = 2_500_000
`ifdef CHANGE_INVENTORY_EN
    ,
    parameter logic [7:0] INV_INIT = 8'd20
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dispense,
    input  logic [7:0] change,
    output logic       eject_25,
    output logic       eject_10,
    output logic       eject_5,
    output logic       busy,
    output logic       done,
    output logic [7:0] short_amt
`ifdef CHANGE_INVENTORY_EN
    ,
    input  logic       refill,
    output logic       empty_25,
    output logic       empty_10,
    output logic       empty_5
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_EJECT  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    // The timer only ever holds PULSE_CYCLES-1 or GAP_CYCLES-1 and counts down to zero.
    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

    logic [2:0]    state_reg, state_next;
    logic          dispense_d_reg;
    logic [7:0]    remaining_reg, remaining_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [2:0]    sel_reg, sel_next;      // one-hot coin: [2]=25, [1]=10, [0]=5
    logic [2:0]    eject_reg, eject_next;
    logic          done_reg, done_next;
    logic          busy_reg, busy_next;
    logic [7:0]    short_reg, short_next;

    logic [2:0]    avail;
    logic [2:0]    pick;
    logic [7:0]    coin_val;
    logic          last_eject;
    logic          start;

    assign start      = (state_reg == S_IDLE) && dispense && !dispense_d_reg;
    assign last_eject = (state_reg == S_EJECT) && (timer_reg == '0);

`ifdef CHANGE_INVENTORY_EN
    logic [2:0] empty_flags;

    for (genvar gi = 0; gi < 3; gi++) begin : g_tube
        logic [7:0] count_reg;
        logic [7:0] count_next;
        logic       empty_reg;

        // Refill takes priority over a decrement landing in the same cycle.
        always_comb begin
            count_next = count_reg;
            if (refill) begin
                count_next = INV_INIT;
            end else if (last_eject && sel_reg[gi]) begin
                count_next = count_reg - 8'd1;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                count_reg <= INV_INIT;
                empty_reg <= (INV_INIT == 8'd0);
            end else begin
                count_reg <= count_next;
                empty_reg <= (count_next == 8'd0);
            end
        end

        assign avail[gi]       = (count_reg != 8'd0);
        assign empty_flags[gi] = empty_reg;
    end

    assign empty_25 = empty_flags[2];
    assign empty_10 = empty_flags[1];
    assign empty_5  = empty_flags[0];
`else
    assign avail = 3'b111;
`endif

    // Largest coin that both fits in the remaining amount and is in stock.
    always_comb begin
        pick = 3'b000;
        if (remaining_reg >= 8'd25 && avail[2]) begin
            pick = 3'b100;
        end else if (remaining_reg >= 8'd10 && avail[1]) begin
            pick = 3'b010;
        end else if (remaining_reg >= 8'd5 && avail[0]) begin
            pick = 3'b001;
        end
    end

    always_comb begin
        coin_val = 8'd0;
        if (sel_reg[2]) begin
            coin_val = 8'd25;
        end else if (sel_reg[1]) begin
            coin_val = 8'd10;
        end else if (sel_reg[0]) begin
            coin_val = 8'd5;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        timer_next     = timer_reg;
        sel_next       = sel_reg;
        eject_next     = eject_reg;
        short_next     = short_reg;
        done_next      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    remaining_next = change;
                    short_next     = 8'd0;
                    state_next     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (pick != 3'b000) begin
                    sel_next   = pick;
                    eject_next = pick;
                    timer_next = PULSE_LOAD;
                    state_next = S_EJECT;
                end else begin
                    done_next  = 1'b1;
                    state_next = S_FINISH;
                end
            end
            S_EJECT: begin
                if (timer_reg == '0) begin
                    remaining_next = remaining_reg - coin_val;
                    eject_next     = 3'b000;
                    timer_next     = GAP_LOAD;
                    state_next     = S_GAP;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            S_GAP: begin
                if (timer_reg == '0) begin
                    state_next = S_SELECT;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            S_FINISH: begin
                short_next = remaining_reg;
                state_next = S_IDLE;
            end
            default: begin
                eject_next = 3'b000;
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            dispense_d_reg <= 1'b0;
            remaining_reg  <= 8'd0;
            timer_reg      <= '0;
            sel_reg        <= 3'b000;
            eject_reg      <= 3'b000;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            short_reg      <= 8'd0;
        end else begin
            state_reg      <= state_next;
            dispense_d_reg <= dispense;
            remaining_reg  <= remaining_next;
            timer_reg      <= timer_next;
            sel_reg        <= sel_next;
            eject_reg      <= eject_next;
            done_reg       <= done_next;
            busy_reg       <= busy_next;
            short_reg      <= short_next;
        end
    end

    assign eject_25  = eject_reg[2];
    assign eject_10  = eject_reg[1];
    assign eject_5   = eject_reg[0];
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign short_amt = short_reg;

endmodule
